// File: rtl/fir_pkg.sv
// Shared widths for the three-tap FIR datapath.
package fir_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned COEF_W = 8;
   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned TAPS   = 3;
   // Headroom for summing TAPS full-width products before wrapping to OUT_W.
   localparam int unsigned SUM_W  = PROD_W + 2;

endpackage

// File: rtl/fir_braun_multiplier.sv
// Unsigned Braun array multiplier: carry-save AND/full-adder array with a
// ripple-carry final row, plus the full_adder cell it is built from.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module braun_multiplier
   import fir_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [COEF_W-1:0] b_i,
   output logic [PROD_W-1:0] p_o
);

   localparam int unsigned N = DATA_W;
   localparam int unsigned M = COEF_W;

   // s_w[i][j] has weight i+j; c_w[i][j] has weight i+j+1.
   logic s_w  [M][N];
   logic c_w  [M][N];
   logic rc_w [N];

   for (genvar j = 0; j < N; j++) begin : g_row0
      assign s_w[0][j] = a_i[j] & b_i[0];
      assign c_w[0][j] = 1'b0;
   end

   for (genvar i = 1; i < M; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic sin_w;
         if (j < N - 1) begin : g_mid
            assign sin_w = s_w[i-1][j+1];
         end else begin : g_edge
            assign sin_w = 1'b0;
         end
         full_adder u_fa (
            .a_i  (a_i[j] & b_i[i]),
            .b_i  (sin_w),
            .c_i  (c_w[i-1][j]),
            .s_o  (s_w[i][j]),
            .co_o (c_w[i][j])
         );
      end
   end

   for (genvar i = 0; i < M; i++) begin : g_low
      assign p_o[i] = s_w[i][0];
   end

   // Final ripple row merges the remaining sum and carry vectors.
   assign rc_w[0] = 1'b0;
   for (genvar k = 0; k < N - 1; k++) begin : g_rip
      full_adder u_fa (
         .a_i  (s_w[M-1][k+1]),
         .b_i  (c_w[M-1][k]),
         .c_i  (rc_w[k]),
         .s_o  (p_o[M+k]),
         .co_o (rc_w[k+1])
      );
   end
   // Top bit cannot carry out: the product always fits in PROD_W bits.
   assign p_o[M+N-1] = c_w[M-1][N-1] ^ rc_w[N-1];

endmodule

// File: rtl/fir_top.sv
// Three-tap direct-form FIR: delay line, product sum wrapped to 16 bits,
// and a registered output.
module fir_top
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] Xin,
   input  logic [COEF_W-1:0] H0,
   input  logic [COEF_W-1:0] H1,
   input  logic [COEF_W-1:0] H2,
   output logic [OUT_W-1:0]  Yout
);

   logic [DATA_W-1:0] d1_q, d1_d;
   logic [DATA_W-1:0] d2_q, d2_d;
   logic [OUT_W-1:0]  y_q, y_d;
   logic [PROD_W-1:0] p0_w, p1_w, p2_w;

   braun_multiplier u_mul0 (.a_i(Xin),  .b_i(H0), .p_o(p0_w));
   braun_multiplier u_mul1 (.a_i(d1_q), .b_i(H1), .p_o(p1_w));
   braun_multiplier u_mul2 (.a_i(d2_q), .b_i(H2), .p_o(p2_w));

   // Sum at full width, then keep the low bits: wrap-around, no saturation.
   always_comb begin
      d1_d = Xin;
      d2_d = d1_q;
      y_d  = OUT_W'(SUM_W'(p0_w) + SUM_W'(p1_w) + SUM_W'(p2_w));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d1_q <= '0;
         d2_q <= '0;
         y_q  <= '0;
      end else begin
         d1_q <= d1_d;
         d2_q <= d2_d;
         y_q  <= y_d;
      end
   end

   assign Yout = y_q;

endmodule

// File: tb/tb_fir_top.sv
// Self-checking bench for fir_top against a history-based FIR model,
// plus an exhaustive sweep of the array multiplier.
module tb_fir_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  Xin, H0, H1, H2;
   logic [15:0] Yout;

   logic [7:0]  ma, mb;
   logic [15:0] mp;

   int errors = 0;
   int checks = 0;

   // Reference model state: last two accepted samples and expected output.
   int m_hist [2];
   int m_y;

   always #5 clk = ~clk;

   fir_top dut (
      .clk  (clk),
      .rst  (rst),
      .Xin  (Xin),
      .H0   (H0),
      .H1   (H1),
      .H2   (H2),
      .Yout (Yout)
   );

   braun_multiplier u_mul (.a_i(ma), .b_i(mb), .p_o(mp));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge: drive on the falling edge, advance model, sample after the rising edge.
   task automatic step(input logic r, input int x, input int h0, input int h1,
                       input int h2, input int exp_lit, input string tag);
      int acc;
      @(negedge clk);
      rst = r;
      Xin = 8'(x);
      H0  = 8'(h0);
      H1  = 8'(h1);
      H2  = 8'(h2);
      if (r) begin
         m_hist[0] = 0;
         m_hist[1] = 0;
         m_y       = 0;
      end else begin
         acc       = h0 * x + h1 * m_hist[0] + h2 * m_hist[1];
         m_y       = acc % 65536;
         m_hist[1] = m_hist[0];
         m_hist[0] = x;
      end
      @(posedge clk);
      #1;
      check(tag, int'(Yout), m_y);
      if (exp_lit >= 0) check({tag, "_lit"}, int'(Yout), exp_lit);
   endtask

   int ref_x [9]   = '{3, 1, 1, 2, 1, 4, 5, 6, 0};
   int ref_y [9]   = '{30, 70, 120, 70, 80, 120, 160, 280, 270};
   int ovf_y [3]   = '{65025, 64514, 64003};

   initial begin
      int mism;
      rst = 1'b1; Xin = 8'd7; H0 = 8'd10; H1 = 8'd20; H2 = 8'd30;
      m_hist[0] = 0; m_hist[1] = 0; m_y = 0;
      ma = '0; mb = '0;

      // Reset held two edges, then first edge after release.
      step(1'b1, 7, 10, 20, 30, 0, "rst_a");
      step(1'b1, 7, 10, 20, 30, 0, "rst_b");
      step(1'b0, 0, 10, 20, 30, 0, "post_rst");

      // Reference sequence from a cleared delay line.
      for (int i = 0; i < 9; i++)
         step(1'b0, ref_x[i], 10, 20, 30, ref_y[i], $sformatf("ref%0d", i));

      // Mid-stream reset once the sequence reaches 160.
      step(1'b1, 0, 10, 20, 30, 0, "pre_mid");
      for (int i = 0; i < 7; i++)
         step(1'b0, ref_x[i], 10, 20, 30, ref_y[i], $sformatf("mid%0d", i));
      step(1'b1, 9, 10, 20, 30, 0, "mid_rst");
      step(1'b0, 3, 10, 20, 30, 30, "mid_resume");

      // Impulse response.
      step(1'b1, 0, 10, 20, 30, 0, "imp_rst");
      step(1'b0, 1, 10, 20, 30, 10, "imp0");
      step(1'b0, 0, 10, 20, 30, 20, "imp1");
      step(1'b0, 0, 10, 20, 30, 30, "imp2");
      step(1'b0, 0, 10, 20, 30, 0, "imp3");

      // Overflow wrap with all-ones operands.
      step(1'b1, 0, 255, 255, 255, 0, "ovf_rst");
      for (int i = 0; i < 3; i++)
         step(1'b0, 255, 255, 255, 255, ovf_y[i], $sformatf("ovf%0d", i));

      // Coefficient change takes effect on the next edge without transient.
      step(1'b1, 0, 1, 1, 1, 0, "coef_rst");
      step(1'b0, 2, 1, 1, 1, 2, "coef0");
      step(1'b0, 2, 1, 1, 1, 4, "coef1");
      step(1'b0, 2, 1, 1, 1, 6, "coef2");
      step(1'b0, 2, 5, 1, 1, 14, "coef_sw");
      step(1'b0, 2, 5, 1, 1, 14, "coef_hold");

      // Randomized samples, coefficients and occasional reset.
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 31) == 0), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), -1, $sformatf("rnd%0d", i));

      // Exhaustive multiplier sweep.
      mism = 0;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            ma = 8'(a);
            mb = 8'(b);
            #1;
            if (int'(mp) != a * b) begin
               if (mism == 0) check($sformatf("mul_%0dx%0d", a, b), int'(mp), a * b);
               mism++;
            end
         end
      end
      check("mul_sweep_mismatches", mism, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
